cmd_line_rx: RTL and testbench

//  Input side of the text console: collects typed ASCII bytes into a line buffer, edits on backspace,

---
 rtl/cmd_line_rx.sv | 214 +++++++++++++++++++++
 tb/tb_cmd_line_rx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_line_rx.sv
// Console line receiver: buffers typed bytes, edits on backspace and matches the line on Enter.
// Optional keystroke echo is enabled by defining CMD_ECHO_EN.
module cmd_line_rx #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic             prompt_ready,
    output logic             cmd_valid,
    output logic [1:0]       cmd_id,
    output logic             no_com,
    output logic             empty_line,
`ifdef CMD_ECHO_EN
    output logic [7:0]       echo_data,
    output logic             echo_valid,
`endif
    output logic [LEN_W-1:0] line_len
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {S_COLLECT, S_MATCH, S_REPORT, S_GUARD, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] line_len_q, line_len_d;
    logic             ovf_q, ovf_d;
    logic [1:0]       idx_q, idx_d;
    logic             found_q, found_d;
    logic [1:0]       fid_q, fid_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [1:0]       cmd_id_q, cmd_id_d;
    logic             no_com_q, no_com_d;
    logic             empty_q, empty_d;
    logic [7:0]       buf_q [MAX_LEN];
    logic [7:0]       buf_d [MAX_LEN];
    logic             accept;
    logic             entry_hit;
`ifdef CMD_ECHO_EN
    logic [7:0]       echo_data_q, echo_data_d;
    logic             echo_valid_q, echo_valid_d;
`endif

    function automatic logic [2:0] cmd_len(input logic [1:0] id);
        case (id)
            2'd0:    return 3'd4;
            2'd1:    return 3'd5;
            2'd2:    return 3'd3;
            default: return 3'd5;
        endcase
    endfunction

    function automatic logic [7:0] cmd_char(input logic [1:0] id, input logic [2:0] pos);
        logic [39:0] s;
        case (id)
            2'd0:    s = {"help", 8'h00};
            2'd1:    s = "clear";
            2'd2:    s = {"led", 16'h0000};
            default: s = "reset";
        endcase
        case (pos)
            3'd0:    return s[39:32];
            3'd1:    return s[31:24];
            3'd2:    return s[23:16];
            3'd3:    return s[15:8];
            default: return s[7:0];
        endcase
    endfunction

    // Compare the buffered line against the table entry selected by idx_q
    always_comb begin
        entry_hit = !ovf_q && (line_len_q == LEN_W'(cmd_len(idx_q)));
        for (int i = 0; i < 5; i++) begin
            if (i < MAX_LEN && 3'(i) < cmd_len(idx_q)) begin
                if (buf_q[IDX_W'(i)] != cmd_char(idx_q, 3'(i))) entry_hit = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_COLLECT;
            line_len_q   <= '0;
            ovf_q        <= 1'b0;
            idx_q        <= 2'd0;
            found_q      <= 1'b0;
            fid_q        <= 2'd0;
            cmd_valid_q  <= 1'b0;
            cmd_id_q     <= 2'd0;
            no_com_q     <= 1'b0;
            empty_q      <= 1'b0;
`ifdef CMD_ECHO_EN
            echo_data_q  <= 8'h00;
            echo_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            line_len_q   <= line_len_d;
            ovf_q        <= ovf_d;
            idx_q        <= idx_d;
            found_q      <= found_d;
            fid_q        <= fid_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_id_q     <= cmd_id_d;
            no_com_q     <= no_com_d;
            empty_q      <= empty_d;
`ifdef CMD_ECHO_EN
            echo_data_q  <= echo_data_d;
            echo_valid_q <= echo_valid_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: if (accept && rx_data == 8'h0D)
                           state_d = (line_len_q == '0 && !ovf_q) ? S_REPORT : S_MATCH;
            S_MATCH:   if (idx_q == 2'd3) state_d = S_REPORT;
            S_REPORT:  state_d = S_GUARD;
            S_GUARD:   state_d = S_WAIT;
            S_WAIT:    if (prompt_ready) state_d = S_COLLECT;
            default:   state_d = S_COLLECT;
        endcase
    end

    always_comb begin
        rx_ready   = (state_q == S_COLLECT);
        accept     = rx_valid && rx_ready;
        cmd_valid  = cmd_valid_q;
        cmd_id     = cmd_id_q;
        no_com     = no_com_q;
        empty_line = empty_q;
        line_len   = line_len_q;
`ifdef CMD_ECHO_EN
        echo_data  = echo_data_q;
        echo_valid = echo_valid_q;
`endif
    end

    always_comb begin
        line_len_d  = line_len_q;
        ovf_d       = ovf_q;
        buf_d       = buf_q;
        idx_d       = idx_q;
        found_d     = found_q;
        fid_d       = fid_q;
        cmd_valid_d = 1'b0;
        cmd_id_d    = 2'd0;
        no_com_d    = 1'b0;
        empty_d     = 1'b0;
`ifdef CMD_ECHO_EN
        echo_data_d  = 8'h00;
        echo_valid_d = 1'b0;
`endif
        case (state_q)
            S_COLLECT: begin
                idx_d   = 2'd0;
                found_d = 1'b0;
                fid_d   = 2'd0;
                if (accept) begin
                    if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
                        if (line_len_q < MAX_LEN_L) begin
                            buf_d[line_len_q[IDX_W-1:0]] = rx_data;
                            line_len_d = line_len_q + 1'b1;
`ifdef CMD_ECHO_EN
                            echo_data_d  = rx_data;
                            echo_valid_d = 1'b1;
`endif
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (rx_data == 8'h08 || rx_data == 8'h7F) begin
                        if (line_len_q != '0) begin
                            line_len_d = line_len_q - 1'b1;
`ifdef CMD_ECHO_EN
                            echo_data_d  = 8'h08;
                            echo_valid_d = 1'b1;
`endif
                        end
                    end else if (rx_data == 8'h0D) begin
                        empty_d = (line_len_q == '0 && !ovf_q);
                    end
                end
            end
            S_MATCH: begin
                found_d = found_q | entry_hit;
                fid_d   = (entry_hit && !found_q) ? idx_q : fid_q;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    cmd_valid_d = found_d;
                    cmd_id_d    = found_d ? fid_d : 2'd0;
                    no_com_d    = !found_d;
                end
            end
            S_WAIT: begin
                if (prompt_ready) begin
                    line_len_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cmd_line_rx.sv
// Self-checking bench for cmd_line_rx: directed line scenarios plus randomized lines
// checked against a queue-based model of the line editor and command table.
module tb_cmd_line_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       prompt_ready;
    logic       cmd_valid;
    logic [1:0] cmd_id;
    logic       no_com;
    logic       empty_line;
    logic [4:0] line_len;
`ifdef CMD_ECHO_EN
    logic [7:0] echo_data;
    logic       echo_valid;
`endif

    int checks = 0;
    int errors = 0;

    byte unsigned mq[$];
    bit           movf = 1'b0;
    string        tbl[4] = '{"help", "clear", "led", "reset"};

    always #5 clk = ~clk;

    cmd_line_rx #(.MAX_LEN(16), .LEN_W(5)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .prompt_ready(prompt_ready), .cmd_valid(cmd_valid), .cmd_id(cmd_id), .no_com(no_com),
        .empty_line(empty_line),
`ifdef CMD_ECHO_EN
        .echo_data(echo_data), .echo_valid(echo_valid),
`endif
        .line_len(line_len)
    );

    task automatic model_byte(input byte unsigned b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            if (mq.size() < 16) mq.push_back(b);
            else movf = 1'b1;
        end else if (b == 8'h08 || b == 8'h7F) begin
            if (mq.size() > 0) void'(mq.pop_back());
        end
    endtask

    // 0 = empty line, 1 = command match, 2 = no command
    function automatic int model_result(output int id);
        bit same;
        id = 0;
        if (mq.size() == 0 && !movf) return 0;
        if (movf) return 2;
        for (int i = 0; i < 4; i++) begin
            if (tbl[i].len() == mq.size()) begin
                same = 1'b1;
                for (int j = 0; j < mq.size(); j++)
                    if (tbl[i][j] != mq[j]) same = 1'b0;
                if (same) begin
                    id = i;
                    return 1;
                end
            end
        end
        return 2;
    endfunction

    task automatic send_byte(input byte unsigned b);
        @(negedge clk);
        checks++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL rdy_collect: rx_ready=%b required 1", rx_ready);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic check_len(input string name);
        checks++;
        if (line_len !== 5'(mq.size())) begin
            errors++;
            $display("FAIL %s line_len: got %0d required %0d", name, line_len, mq.size());
        end
    endtask

    task automatic enter_and_check(input string name, input bit pr_high, input int wait_cycles);
        int id, kind, s, last, exp_len;
        logic [4:0] exp_v, obs_v;
        logic       exp_rdy;
        kind    = model_result(id);
        s       = (kind == 0) ? 1 : 5;
        exp_len = mq.size();
        last    = pr_high ? s + 3 : s + 2 + wait_cycles;
        @(negedge clk);
        rx_valid     = 1'b1;
        rx_data      = 8'h0D;
        prompt_ready = pr_high;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            exp_v = 5'b0;
            if (k == s) begin
                case (kind)
                    0:       exp_v = 5'b00001;
                    1:       exp_v = {1'b1, id[1:0], 2'b00};
                    default: exp_v = 5'b00010;
                endcase
            end
            obs_v = {cmd_valid, cmd_id, no_com, empty_line};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL %s strobes k=%0d: got {cv,id,nc,el}=%b required %b", name, k, obs_v, exp_v);
            end
            exp_rdy = (pr_high && k == last);
            checks++;
            if (rx_ready !== exp_rdy) begin
                errors++;
                $display("FAIL %s rx_ready k=%0d: got %b required %b", name, k, rx_ready, exp_rdy);
            end
            if (!pr_high && k >= s + 1) begin
                rx_valid = 1'b1;
                rx_data  = 8'h71;
            end else begin
                rx_valid = 1'b0;
            end
        end
        if (pr_high) begin
            prompt_ready = 1'b0;
            checks++;
            if (line_len !== 5'd0) begin
                errors++;
                $display("FAIL %s len_after_wait: got %0d required 0", name, line_len);
            end
        end else begin
            checks++;
            if (line_len !== 5'(exp_len)) begin
                errors++;
                $display("FAIL %s len_held: got %0d required %0d", name, line_len, exp_len);
            end
            rx_valid     = 1'b0;
            prompt_ready = 1'b1;
            @(negedge clk);
            prompt_ready = 1'b0;
            checks++;
            if (rx_ready !== 1'b1 || line_len !== 5'd0) begin
                errors++;
                $display("FAIL %s wait_exit: rx_ready=%b line_len=%0d required 1 and 0", name, rx_ready, line_len);
            end
        end
        mq.delete();
        movf = 1'b0;
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (rx_ready !== 1'b1 || line_len !== 5'd0 || cmd_valid !== 1'b0 || cmd_id !== 2'd0 ||
            no_com !== 1'b0 || empty_line !== 1'b0) begin
            errors++;
            $display("FAIL %s: rdy=%b len=%0d cv=%b id=%0d nc=%b el=%b required 1 0 0 0 0 0",
                     name, rx_ready, line_len, cmd_valid, cmd_id, no_com, empty_line);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; prompt_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_idle("after_reset");
    endtask

    task automatic test_commands();
        send_str("led");   check_len("led");  enter_and_check("led", 1'b0, 3);
        send_str("xyz");   check_len("xyz");  enter_and_check("xyz", 1'b0, 2);
        for (int i = 0; i < 4; i++) begin
            send_str(tbl[i]);
            enter_and_check("table", 1'b1, 0);
        end
    endtask

    task automatic test_backspace();
        send_byte(8'h08);  check_len("bs_empty");
        send_str("helq"); send_byte(8'h08); send_str("p");
        check_len("helq_bs_p");
        enter_and_check("helq_bs_p", 1'b0, 1);
        send_str("cl"); send_byte(8'h0A); send_byte(8'h01); send_byte(8'h80); send_str("ear");
        check_len("ignored_codes");
        enter_and_check("ignored_codes", 1'b1, 0);
        send_str("reset"); send_byte(8'h7F); send_byte(8'h7F);
        check_len("del_7f");
        enter_and_check("del_7f", 1'b0, 0);
    endtask

    task automatic test_empty();
        enter_and_check("enter_alone", 1'b0, 2);
        send_str("he"); send_byte(8'h08); send_byte(8'h08);
        check_len("he_bs_bs");
        enter_and_check("he_bs_bs", 1'b1, 0);
    endtask

    task automatic test_overflow();
        repeat (20) send_byte(8'h61);
        check_len("ovf20");
        enter_and_check("ovf20", 1'b0, 1);
        repeat (17) send_byte(8'h61);
        repeat (17) send_byte(8'h08);
        check_len("ovf_then_erase");
        enter_and_check("ovf_then_erase", 1'b1, 0);
    endtask

    task automatic test_wait_hold();
        send_str("help");
        enter_and_check("wait_hold", 1'b0, 20);
    endtask

    task automatic test_reset_mid(input int kr);
        logic [3:0] obs;
        send_str("led");
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h0D;
        for (int k = 1; k <= kr; k++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset_mid");
        mq.delete(); movf = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            obs = {cmd_valid, no_com, empty_line, rx_ready};
            checks++;
            if (obs !== 4'b0001) begin
                errors++;
                $display("FAIL reset_mid_quiet k=%0d: got {cv,nc,el,rdy}=%b required 0001", k, obs);
            end
        end
        send_str("clear");
        enter_and_check("after_reset_mid", 1'b1, 0);
    endtask

    task automatic test_random();
        byte unsigned line[$];
        int mode, r;
        for (int n = 0; n < 40; n++) begin
            line.delete();
            mode = $urandom_range(0, 4);
            r    = $urandom_range(0, 3);
            case (mode)
                0: for (int j = 0; j < tbl[r].len(); j++) line.push_back(tbl[r][j]);
                1: begin
                    for (int j = 0; j < tbl[r].len(); j++) line.push_back(tbl[r][j]);
                    if ($urandom_range(0, 1) == 0) line[$] = 8'(line[$] ^ 8'h20);
                    else line.push_back(8'h73);
                end
                2: repeat ($urandom_range(0, 6)) line.push_back(8'($urandom_range(32, 126)));
                3: begin
                    for (int j = 0; j < tbl[r].len(); j++) begin
                        line.push_back(tbl[r][j]);
                        if ($urandom_range(0, 3) == 0) begin
                            line.push_back(8'($urandom_range(32, 126)));
                            line.push_back(($urandom_range(0, 1) == 0) ? 8'h08 : 8'h7F);
                        end
                    end
                end
                default: repeat ($urandom_range(14, 22)) line.push_back(8'($urandom_range(32, 126)));
            endcase
            if ($urandom_range(0, 3) == 0) line.insert($urandom_range(0, line.size()), 8'h0A);
            if ($urandom_range(0, 4) == 0) line.insert(0, 8'h08);
            foreach (line[j]) send_byte(line[j]);
            check_len("rand_len");
            enter_and_check("rand", 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_commands();
        test_backspace();
        test_empty();
        test_overflow();
        test_wait_hold();
        test_reset_mid(2);
        test_reset_mid(9);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
